// File: rtl/ro_puf_sequencer.sv
// Ring-oscillator PUF sequencer: measures one oscillator pair per response bit.
// Define RO_PUF_TIE_DETECT_EN to report equal counts on tie_mask.
module ro_puf_sequencer #(
  parameter int SEL_W     = 4,
  parameter int CNT_W     = 16,
  parameter int RESP_BITS = 8,
  parameter int WINDOW    = 1024
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [RESP_BITS*2*SEL_W-1:0]  challenge,
  input  logic [CNT_W-1:0]              cnt_a,
  input  logic [CNT_W-1:0]              cnt_b,
  output logic [SEL_W-1:0]              sel_a,
  output logic [SEL_W-1:0]              sel_b,
  output logic                          ro_en,
  output logic                          cnt_clr,
  output logic                          busy,
  output logic                          done,
  output logic [RESP_BITS-1:0]          response,
  output logic                          err,
  output logic [RESP_BITS-1:0]          tie_mask
);

  localparam int IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int WIN_W = 16;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT,
    S_DRAIN,
    S_COMPARE,
    S_DONE
  } state_t;

  state_t                         r_state;
  logic [RESP_BITS*2*SEL_W-1:0]   r_chal;
  logic [IDX_W-1:0]               r_idx;
  logic [WIN_W-1:0]               r_win;

  logic [IDX_W-1:0]               w_pairIdx;
  logic [RESP_BITS*2*SEL_W-1:0]   w_chalSrc;
  logic [SEL_W-1:0]               w_nextA;
  logic [SEL_W-1:0]               w_nextB;

  // Selects for the pair about to be measured: pair 0 of the incoming
  // challenge when starting, otherwise the next pair of the stored one.
  always_comb begin
    w_pairIdx = (r_state == S_IDLE) ? '0 : r_idx + 1'b1;
    w_chalSrc = (r_state == S_IDLE) ? challenge : r_chal;
    w_nextA   = w_chalSrc[2*SEL_W*int'(w_pairIdx) +: SEL_W];
    w_nextB   = w_chalSrc[2*SEL_W*int'(w_pairIdx) + SEL_W +: SEL_W];
  end

`ifdef RO_PUF_TIE_DETECT_EN
  logic [RESP_BITS-1:0] r_tie;
  assign tie_mask = r_tie;
`else
  assign tie_mask = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_chal   <= '0;
      r_idx    <= '0;
      r_win    <= '0;
      sel_a    <= '0;
      sel_b    <= '0;
      ro_en    <= 1'b0;
      cnt_clr  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      response <= '0;
      err      <= 1'b0;
`ifdef RO_PUF_TIE_DETECT_EN
      r_tie    <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chal   <= challenge;
            r_idx    <= '0;
            response <= '0;
            err      <= 1'b0;
`ifdef RO_PUF_TIE_DETECT_EN
            r_tie    <= '0;
`endif
            sel_a    <= w_nextA;
            sel_b    <= w_nextB;
            cnt_clr  <= 1'b1;
            busy     <= 1'b1;
            r_state  <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          cnt_clr <= 1'b0;
          ro_en   <= 1'b1;
          r_win   <= WIN_W'(WINDOW - 1);
          r_state <= S_COUNT;
        end
        S_COUNT: begin
          if (r_win == '0) begin
            ro_en   <= 1'b0;
            r_win   <= WIN_W'(1);
            r_state <= S_DRAIN;
          end else begin
            r_win <= r_win - 1'b1;
          end
        end
        // Two idle cycles let the counters' synchronisers settle.
        S_DRAIN: begin
          if (r_win == '0) begin
            r_state <= S_COMPARE;
          end else begin
            r_win <= r_win - 1'b1;
          end
        end
        S_COMPARE: begin
          if (sel_a == sel_b) begin
            response[r_idx] <= 1'b0;
            err             <= 1'b1;
          end else begin
            response[r_idx] <= (cnt_a > cnt_b);
          end
`ifdef RO_PUF_TIE_DETECT_EN
          if (cnt_a == cnt_b) begin
            r_tie[r_idx] <= 1'b1;
          end
`endif
          if (r_idx == LAST_IDX) begin
            done    <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
            sel_a   <= w_nextA;
            sel_b   <= w_nextB;
            cnt_clr <= 1'b1;
            r_state <= S_CLEAR;
          end
        end
        S_DONE: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ro_puf_sequencer.sv
// Directed self-checking bench for ro_puf_sequencer (WINDOW=4, RESP_BITS=2).
// Builds with or without RO_PUF_TIE_DETECT_EN; tie expectations follow the macro.
module tb_ro_puf_sequencer;

  localparam int SEL_W     = 4;
  localparam int CNT_W     = 16;
  localparam int RESP_BITS = 2;
  localparam int WINDOW    = 4;

  // Start-sampling edge counts as cycle 1; 1 + 2*(4+4) = 17.
  localparam int DONE_CYCLE = 17;
  // Cycles per response bit: clear 1, count 4, drain 2, compare 1.
  localparam int BIT_CYCLES = 8;

`ifdef RO_PUF_TIE_DETECT_EN
  localparam logic TIE_ON = 1'b1;
`else
  localparam logic TIE_ON = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         rst;
  logic                         start;
  logic [RESP_BITS*2*SEL_W-1:0] challenge;
  logic [CNT_W-1:0]             cnt_a;
  logic [CNT_W-1:0]             cnt_b;
  logic [SEL_W-1:0]             sel_a;
  logic [SEL_W-1:0]             sel_b;
  logic                         ro_en;
  logic                         cnt_clr;
  logic                         busy;
  logic                         done;
  logic [RESP_BITS-1:0]         response;
  logic                         err;
  logic [RESP_BITS-1:0]         tie_mask;

  int vectors     = 0;
  int miscompares = 0;

  // Edge count each oscillator reaches over one window.
  logic [CNT_W-1:0] freq [16];

  ro_puf_sequencer #(
    .SEL_W     (SEL_W),
    .CNT_W     (CNT_W),
    .RESP_BITS (RESP_BITS),
    .WINDOW    (WINDOW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .challenge (challenge),
    .cnt_a     (cnt_a),
    .cnt_b     (cnt_b),
    .sel_a     (sel_a),
    .sel_b     (sel_b),
    .ro_en     (ro_en),
    .cnt_clr   (cnt_clr),
    .busy      (busy),
    .done      (done),
    .response  (response),
    .err       (err),
    .tie_mask  (tie_mask)
  );

  always #5 clk = ~clk;

  // Counter stand-in: cleared by cnt_clr, shows the oscillator's count once enabled.
  always @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (ro_en) begin
      cnt_a <= freq[sel_a];
      cnt_b <= freq[sel_b];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues a one-cycle start and watches 40 cycles, leaving the DUT idle.
  task automatic runChallenge(input logic [15:0] chal, output int doneAt, output int donePulses);
    challenge = chal;
    start     = 1'b1;
    tick();
    start      = 1'b0;
    doneAt     = -1;
    donePulses = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) tick();
      if (done === 1'b1) begin
        donePulses++;
        if (doneAt < 0) doneAt = n;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    start     = 1'b0;
    challenge = '0;
    tick();
    tick();
    vectors++;
    if ({busy, done, ro_en, cnt_clr, err} !== 5'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: busy/done/ro_en/cnt_clr/err=%b required 00000",
               {busy, done, ro_en, cnt_clr, err});
    end
    vectors++;
    if (response !== 2'b00 || tie_mask !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_words: response=%b tie_mask=%b required 00/00", response, tie_mask);
    end
    vectors++;
    if (sel_a !== 4'd0 || sel_b !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_sel: sel_a=%0d sel_b=%0d required 0/0", sel_a, sel_b);
    end
    rst = 1'b0;
    tick();
  endtask

  // Pairs (1,2),(3,4): 10>7 -> bit0=1, 5>9 false -> bit1=0; checks phase timing too.
  task automatic test_basic();
    int   doneAt;
    int   phase;
    int   bitNo;
    logic expClr;
    logic expEn;
    logic [3:0] expA;
    logic [3:0] expB;
    doneAt    = -1;
    challenge = 16'h4321;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      if (n > 1) tick();
      phase  = (n - 1) % BIT_CYCLES;
      bitNo  = (n - 1) / BIT_CYCLES;
      expClr = (n <= 16) && (phase == 0);
      expEn  = (n <= 16) && (phase >= 1) && (phase <= WINDOW);
      vectors++;
      if (cnt_clr !== expClr || ro_en !== expEn) begin
        miscompares++;
        $display("[TB] FAIL phase_c%0d: cnt_clr=%b ro_en=%b required %b/%b",
                 n, cnt_clr, ro_en, expClr, expEn);
      end
      expA = (bitNo == 0) ? 4'd1 : 4'd3;
      expB = (bitNo == 0) ? 4'd2 : 4'd4;
      vectors++;
      if (sel_a !== expA || sel_b !== expB) begin
        miscompares++;
        $display("[TB] FAIL sel_c%0d: sel_a=%0d sel_b=%0d required %0d/%0d",
                 n, sel_a, sel_b, expA, expB);
      end
      vectors++;
      if (done !== (n == DONE_CYCLE) || busy !== (n <= DONE_CYCLE)) begin
        miscompares++;
        $display("[TB] FAIL done_busy_c%0d: done=%b busy=%b required %b/%b",
                 n, done, busy, (n == DONE_CYCLE), (n <= DONE_CYCLE));
      end
      if (done === 1'b1 && doneAt < 0) doneAt = n;
    end
    vectors++;
    if (doneAt != DONE_CYCLE) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: done at cycle %0d required %0d", doneAt, DONE_CYCLE);
    end
    vectors++;
    if (response !== 2'b01 || err !== 1'b0 || tie_mask !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL basic_result: response=%b err=%b tie=%b required 01/0/00",
               response, err, tie_mask);
    end
  endtask

  // Pair 0 = (5,6) both count 100 -> bit0=0 and a tie; pair 1 = (1,2) -> bit1=1.
  task automatic test_tie();
    int doneAt;
    int pulses;
    logic [1:0] expTie;
    expTie = TIE_ON ? 2'b01 : 2'b00;
    runChallenge(16'h2165, doneAt, pulses);
    vectors++;
    if (doneAt != DONE_CYCLE || pulses != 1) begin
      miscompares++;
      $display("[TB] FAIL tie_done: at %0d pulses %0d required %0d/1", doneAt, pulses, DONE_CYCLE);
    end
    vectors++;
    if (response !== 2'b10 || err !== 1'b0 || tie_mask !== expTie) begin
      miscompares++;
      $display("[TB] FAIL tie_result: response=%b err=%b tie=%b required 10/0/%b",
               response, err, tie_mask, expTie);
    end
  endtask

  // Pair 1 = (3,3) -> bit1 forced 0 and err; err persists until the next start.
  task automatic test_err();
    int doneAt;
    int pulses;
    logic [1:0] expTie;
    expTie = TIE_ON ? 2'b10 : 2'b00;
    runChallenge(16'h3321, doneAt, pulses);
    vectors++;
    if (doneAt != DONE_CYCLE || response !== 2'b01 || err !== 1'b1 || tie_mask !== expTie) begin
      miscompares++;
      $display("[TB] FAIL err_result: done@%0d response=%b err=%b tie=%b required %0d/01/1/%b",
               doneAt, response, err, tie_mask, DONE_CYCLE, expTie);
    end
    for (int k = 0; k < 5; k++) tick();
    vectors++;
    if (err !== 1'b1 || response !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL err_hold: err=%b response=%b required 1/01", err, response);
    end
    challenge = 16'h4321;
    start     = 1'b1;
    tick();
    start = 1'b0;
    vectors++;
    if (err !== 1'b0 || response !== 2'b00 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL err_clear: err=%b response=%b busy=%b required 0/00/1", err, response, busy);
    end
    for (int k = 0; k < 25; k++) tick();
    vectors++;
    if (err !== 1'b0 || response !== 2'b01 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL err_rerun: err=%b response=%b busy=%b required 0/01/0", err, response, busy);
    end
  endtask

  // Reset in the COUNT phase of bit 1 aborts the run without a done pulse.
  task automatic test_reset_mid();
    int doneAt;
    int pulses;
    challenge = 16'h4321;
    start     = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 2; n <= 10; n++) tick();
    vectors++;
    if (ro_en !== 1'b1 || response !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL mid_precheck: ro_en=%b response=%b required 1/01", ro_en, response);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vectors++;
    if (busy !== 1'b0 || ro_en !== 1'b0 || response !== 2'b00 || cnt_clr !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL mid_reset: busy=%b ro_en=%b response=%b cnt_clr=%b done=%b required 0/0/00/0/0",
               busy, ro_en, response, cnt_clr, done);
    end
    pulses = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (done === 1'b1) pulses++;
    end
    vectors++;
    if (pulses != 0) begin
      miscompares++;
      $display("[TB] FAIL mid_nodone: %0d done pulses required 0", pulses);
    end
    runChallenge(16'h4321, doneAt, pulses);
    vectors++;
    if (doneAt != DONE_CYCLE || pulses != 1 || response !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL mid_rerun: done@%0d pulses=%0d response=%b required %0d/1/01",
               doneAt, pulses, response, DONE_CYCLE);
    end
  endtask

  // start held high: one run per IDLE visit; challenge changes while busy are ignored.
  task automatic test_back_to_back();
    int         pulses;
    int         firstAt;
    int         secondAt;
    logic [1:0] firstResp;
    logic [1:0] secondResp;
    logic       busyAt18;
    logic       busyAt19;
    pulses     = 0;
    firstAt    = -1;
    secondAt   = -1;
    firstResp  = 2'bxx;
    secondResp = 2'bxx;
    busyAt18   = 1'bx;
    busyAt19   = 1'bx;
    challenge  = 16'h4321;
    start      = 1'b1;
    tick();
    for (int n = 1; n <= 40; n++) begin
      if (n > 1) tick();
      if (n == 5) challenge = 16'h2143;
      if (n == 20) start = 1'b0;
      if (n == 18) busyAt18 = busy;
      if (n == 19) busyAt19 = busy;
      if (done === 1'b1) begin
        pulses++;
        if (firstAt < 0) begin
          firstAt   = n;
          firstResp = response;
        end else if (secondAt < 0) begin
          secondAt   = n;
          secondResp = response;
        end
      end
    end
    vectors++;
    if (pulses != 2 || firstAt != DONE_CYCLE || secondAt != 2*DONE_CYCLE + 1) begin
      miscompares++;
      $display("[TB] FAIL b2b_done: pulses=%0d at %0d,%0d required 2 at %0d,%0d",
               pulses, firstAt, secondAt, DONE_CYCLE, 2*DONE_CYCLE + 1);
    end
    vectors++;
    if (firstResp !== 2'b01 || secondResp !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL b2b_resp: first=%b second=%b required 01/10", firstResp, secondResp);
    end
    vectors++;
    if (busyAt18 !== 1'b0 || busyAt19 !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL b2b_busy: c18=%b c19=%b end=%b required 0/1/0", busyAt18, busyAt19, busy);
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) freq[i] = 16'd20;
    freq[1] = 16'd10;
    freq[2] = 16'd7;
    freq[3] = 16'd5;
    freq[4] = 16'd9;
    freq[5] = 16'd100;
    freq[6] = 16'd100;
    rst       = 1'b1;
    start     = 1'b0;
    challenge = '0;

    test_reset();
    test_basic();
    test_tie();
    test_err();
    test_reset_mid();
    test_back_to_back();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
